battle_state_spi_rx: RTL and testbench

// - Upstream stage of the VGA battle renderer: receives MCU game-state frames over SPI (sck, mosi; no chip select).
// - Hunts a sync byte, collects a fixed payload, checks an XOR checksum, and stages good frames.
// - Presents the staged frame to the renderer only at a vsync boundary, so no frame tears mid-scan.

---
 rtl/battle_link_pkg.sv | 17 +
 rtl/spi_sck_sync.sv | 26 ++
 rtl/battle_state_spi_rx.sv | 139 +++++++++++++
 tb/tb_battle_state_spi_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_link_pkg.sv
// Shared constants and types for the MCU-to-renderer battle-state SPI link.
package battle_link_pkg;
  localparam int         FRAME_BYTES = 8;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_W     = 8 * FRAME_BYTES;
  localparam int         BYTE_IDX_W  = $clog2(FRAME_BYTES);

  // Payload byte slots: first byte lands in state_out[7:0]
  localparam logic [BYTE_IDX_W-1:0] IDX_FIRST = '0;
  localparam logic [BYTE_IDX_W-1:0] IDX_LAST  = BYTE_IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_t;
endpackage

// File: rtl/spi_sck_sync.sv
// Two-flop synchroniser for SPI sck/mosi with sck rising-edge detection.
module spi_sck_sync (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  output logic bit_evt,
  output logic bit_val
);
  logic [2:0] r_sck;
  logic [1:0] r_mosi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck  <= '0;
      r_mosi <= '0;
    end else begin
      r_sck  <= {r_sck[1:0], sck};
      r_mosi <= {r_mosi[0], mosi};
    end
  end

  // mosi is taken from the same stage as the synced sck that produced the edge
  assign bit_evt = r_sck[1] & ~r_sck[2];
  assign bit_val = r_mosi[1];
endmodule

// File: rtl/battle_state_spi_rx.sv
// Receives sync-framed, XOR-checked battle-state frames over SPI and
// presents them to the renderer only on a vsync falling edge.
module battle_state_spi_rx
  import battle_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               mosi,
  input  logic               vsync,
  output logic [FRAME_W-1:0] state_out,
  output logic               state_valid,
  output logic               update_pulse,
  output logic               frame_err,
  output logic               dropped,
  output logic [1:0]         dbg_state
);
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic                  w_bit_evt;
  logic                  w_bit_val;
  logic [7:0]            w_byte;
  logic                  w_vs_fall;

  rx_state_t             r_state;
  logic [6:0]            r_sr;
  logic [2:0]            r_bitcnt;
  logic [BYTE_IDX_W-1:0] r_bytecnt;
  logic [7:0]            r_chk;
  logic [FRAME_W-1:0]    r_shadow;
  logic [FRAME_W-1:0]    r_staging;
  logic                  r_pending;
  logic [TO_W-1:0]       r_idle;
  logic [2:0]            r_vs;
  logic [FRAME_W-1:0]    r_state_out;
  logic                  r_valid;
  logic                  r_update;
  logic                  r_err;
  logic                  r_drop;

  spi_sck_sync u_sck_sync (
    .clk     (clk),
    .reset   (reset),
    .sck     (sck),
    .mosi    (mosi),
    .bit_evt (w_bit_evt),
    .bit_val (w_bit_val)
  );

  assign w_byte    = {r_sr, w_bit_val};
  assign w_vs_fall = ~r_vs[1] & r_vs[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_sr        <= '0;
      r_bitcnt    <= '0;
      r_bytecnt   <= IDX_FIRST;
      r_chk       <= '0;
      r_shadow    <= '0;
      r_staging   <= '0;
      r_pending   <= 1'b0;
      r_idle      <= '0;
      r_vs        <= '0;
      r_state_out <= '0;
      r_valid     <= 1'b0;
      r_update    <= 1'b0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_vs     <= {r_vs[1:0], vsync};
      r_update <= 1'b0;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;

      if (w_bit_evt) r_sr <= w_byte[6:0];

      // Commit reads the old staging; a frame completing this cycle re-arms pending below
      if (w_vs_fall && r_pending) begin
        r_state_out <= r_staging;
        r_update    <= 1'b1;
        r_valid     <= 1'b1;
        r_pending   <= 1'b0;
      end

      case (r_state)
        HUNT: begin
          r_idle <= '0;
          if (w_bit_evt && (w_byte == SYNC_BYTE)) begin
            r_bitcnt  <= '0;
            r_bytecnt <= IDX_FIRST;
            r_chk     <= '0;
            r_state   <= PAYLOAD;
          end
        end
        PAYLOAD, CHECK: begin
          if (w_bit_evt) begin
            r_idle   <= '0;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (r_state == PAYLOAD) begin
                r_shadow[{r_bytecnt, 3'b000} +: 8] <= w_byte;
                r_chk     <= r_chk ^ w_byte;
                r_bytecnt <= r_bytecnt + BYTE_IDX_W'(1);
                if (r_bytecnt == IDX_LAST) r_state <= CHECK;
              end else begin
                if (w_byte == r_chk) begin
                  r_staging <= r_shadow;
                  r_pending <= 1'b1;
                  r_drop    <= r_pending & ~w_vs_fall;
                end else begin
                  r_err <= 1'b1;
                end
                r_state <= HUNT;
              end
            end
          end else if (r_idle == TO_LAST) begin
            r_state  <= HUNT;
            r_err    <= 1'b1;
            r_shadow <= '0;
          end else begin
            r_idle <= r_idle + TO_W'(1);
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign state_out    = r_state_out;
  assign state_valid  = r_valid;
  assign update_pulse = r_update;
  assign frame_err    = r_err;
  assign dropped      = r_drop;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_battle_state_spi_rx.sv
// Bench for battle_state_spi_rx: directed frame scenarios plus randomized
// traffic, checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_battle_state_spi_rx;
  import battle_link_pkg::*;

  localparam int TO = 200;
  localparam int EW = FRAME_W + 4;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sck   = 1'b0;
  logic mosi  = 1'b0;
  logic vsync = 1'b1;

  logic [FRAME_W-1:0] state_out;
  logic               state_valid;
  logic               update_pulse;
  logic               frame_err;
  logic               dropped;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  battle_state_spi_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .sck          (sck),
    .mosi         (mosi),
    .vsync        (vsync),
    .state_out    (state_out),
    .state_valid  (state_valid),
    .update_pulse (update_pulse),
    .frame_err    (frame_err),
    .dropped      (dropped),
    .dbg_state    (dbg_state)
  );

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cnt_upd  = 0;
  int cnt_err  = 0;
  int cnt_drop = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Frame-level model: outputs for a pin sample at edge k appear after edge k+2
  logic               m_sck_prev, m_vs_prev, m_in_frame, m_pend, m_valid;
  logic [7:0]         m_win;
  logic [7:0]         m_bytes[$];
  logic [FRAME_W-1:0] m_staging, m_out;
  int                 m_nbits, m_idle;

  task automatic model_step();
    logic evt, vfall, old_pend, upd, err, drp;
    logic [7:0] x;
    logic [FRAME_W-1:0] st;
    if (reset) begin
      m_sck_prev = 0; m_vs_prev = 0; m_in_frame = 0; m_pend = 0; m_valid = 0;
      m_win = 0; m_bytes.delete(); m_staging = 0; m_out = 0; m_nbits = 0; m_idle = 0;
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      return;
    end
    evt = sck & ~m_sck_prev;
    vfall = ~vsync & m_vs_prev;
    m_sck_prev = sck;
    m_vs_prev = vsync;
    old_pend = m_pend;
    upd = 0; err = 0; drp = 0;
    if (vfall && m_pend) begin
      m_out = m_staging; m_valid = 1; upd = 1; m_pend = 0;
    end
    if (evt) begin
      m_win = {m_win[6:0], mosi};
      if (!m_in_frame) begin
        if (m_win == SYNC_BYTE) begin
          m_in_frame = 1; m_nbits = 0; m_bytes.delete(); m_idle = 0;
        end
      end else begin
        m_idle = 0;
        m_nbits++;
        if (m_nbits % 8 == 0) begin
          if (m_bytes.size() < FRAME_BYTES) m_bytes.push_back(m_win);
          else begin
            x = 0;
            foreach (m_bytes[i]) x ^= m_bytes[i];
            if (x == m_win) begin
              st = '0;
              foreach (m_bytes[i]) st[8*i +: 8] = m_bytes[i];
              m_staging = st;
              drp = old_pend & ~vfall;
              m_pend = 1;
            end else err = 1;
            m_in_frame = 0;
          end
        end
      end
    end else if (m_in_frame) begin
      if (m_idle == TO - 1) begin
        m_in_frame = 0; err = 1;
      end else m_idle++;
    end
    exp_q.push_back({m_out, m_valid, upd, err, drp});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare
  initial forever begin
    logic [EW-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {state_out, state_valid, update_pulse, frame_err, dropped}, e);
      cnt_upd  += int'(update_pulse);
      cnt_err  += int'(frame_err);
      cnt_drop += int'(dropped);
    end
  end

  // Driver tasks
  task automatic send_bit(input logic b, input logic vs_fall);
    @(negedge clk);
    mosi = b;
    sck  = 1'b0;
    repeat ($urandom_range(4, 6)) @(negedge clk);
    sck = 1'b1;
    if (vs_fall) vsync = 1'b0;
    repeat ($urandom_range(4, 6)) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) send_bit(v[b], 1'b0);
  endtask

  function automatic logic [7:0] xor_bytes(input logic [FRAME_W-1:0] p);
    logic [7:0] x = 0;
    for (int i = 0; i < FRAME_BYTES; i++) x ^= p[8*i +: 8];
    return x;
  endfunction

  task automatic send_frame(input logic [FRAME_W-1:0] p, input logic [7:0] flip, input logic vs_last);
    logic [7:0] c;
    send_byte(SYNC_BYTE);
    for (int i = 0; i < FRAME_BYTES; i++) send_byte(p[8*i +: 8]);
    c = xor_bytes(p) ^ flip;
    for (int b = 7; b >= 0; b--) send_bit(c[b], vs_last && (b == 0));
    if (vs_last) begin
      repeat (3) @(negedge clk);
      vsync = 1'b1;
    end
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    vsync = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    logic [FRAME_W-1:0] p;
    logic [7:0] flip;
    logic vs_last;
    int b_upd, b_err, b_drop;

    repeat (3) @(negedge clk);
    check("reset_outputs", {state_out, state_valid, update_pulse, frame_err, dropped}, '0);
    check("reset_state", EW'(dbg_state), EW'(HUNT));
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame then vsync
    b_upd = cnt_upd;
    send_frame(64'h0807060504030201, 8'h00, 1'b0);
    check("basic_no_early_commit", state_out, '0);
    vsync_pulse();
    check("basic_state_out", state_out, 64'h0807060504030201);
    check("basic_update_count", cnt_upd - b_upd, 1);
    check("basic_valid", EW'(state_valid), 1);

    // Bad checksum
    b_upd = cnt_upd; b_err = cnt_err;
    send_frame(64'h0807060504030201, 8'h08, 1'b0);
    vsync_pulse();
    check("badchk_err_count", cnt_err - b_err, 1);
    check("badchk_update_count", cnt_upd - b_upd, 0);
    check("badchk_state_out", state_out, 64'h0807060504030201);

    // Garbage bits then sliding lock
    b_upd = cnt_upd;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_frame(64'h1122334455667788, 8'h00, 1'b0);
    vsync_pulse();
    check("slide_state_out", state_out, 64'h1122334455667788);
    check("slide_update_count", cnt_upd - b_upd, 1);

    // Two frames before vsync
    b_upd = cnt_upd; b_drop = cnt_drop;
    send_frame({8{8'h11}}, 8'h00, 1'b0);
    send_frame({8{8'h22}}, 8'h00, 1'b0);
    check("drop_count", cnt_drop - b_drop, 1);
    vsync_pulse();
    check("drop_state_out", state_out, {8{8'h22}});
    check("drop_update_count", cnt_upd - b_upd, 1);

    // Partial frame times out, next frame accepted
    b_upd = cnt_upd; b_err = cnt_err;
    send_byte(SYNC_BYTE); send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    repeat (TO + 20) @(negedge clk);
    check("timeout_err_count", cnt_err - b_err, 1);
    send_frame(64'h0123456789ABCDEF, 8'h00, 1'b0);
    vsync_pulse();
    check("timeout_recover_state", state_out, 64'h0123456789ABCDEF);
    check("timeout_recover_update", cnt_upd - b_upd, 1);

    // Checksum completes on the vsync edge
    b_upd = cnt_upd; b_drop = cnt_drop;
    send_frame(64'h0F0E0D0C0B0A0908, 8'h00, 1'b0);
    send_frame({8{8'h33}}, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("simul_old_committed", state_out, 64'h0F0E0D0C0B0A0908);
    check("simul_no_drop", cnt_drop - b_drop, 0);
    vsync_pulse();
    check("simul_new_committed", state_out, {8{8'h33}});
    check("simul_update_count", cnt_upd - b_upd, 2);

    // Reset mid-frame
    send_byte(SYNC_BYTE); send_byte(8'h44); send_byte(8'h55);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_state_out", state_out, '0);
    check("midreset_valid", EW'(state_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      int ng;
      ng = $urandom_range(0, 5);
      for (int g = 0; g < ng; g++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        send_byte(SYNC_BYTE);
        send_byte(8'($urandom));
        repeat (TO + 10) @(negedge clk);
      end
      p = {$urandom, $urandom};
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      vs_last = ($urandom_range(0, 4) == 0);
      send_frame(p, flip, vs_last);
      if ($urandom_range(0, 1) == 1) vsync_pulse();
    end
    vsync_pulse();
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
